pulse_stretcher: RTL

Converts single-cycle pulses into clean level windows of fixed width with a guaranteed low gap between windows, queuing pulses that arrive while a window is in progress. It is the pulse-to-level counterpart of the SDRAM controller's rising-edge detector. Any pulse-generating logic can drive a level-sensitive consumer, or a downstream edge detector, without losing or merging events.

---
 rtl/pulse_stretcher.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into HIGH_CYCLES-wide windows separated by at least GAP_CYCLES low cycles.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN: events during HIGH extend the window instead of queuing.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3,
  localparam int PW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pulso,
  input  logic          clear,
  output logic          sinal,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] DEPTH     = PW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          sinal_q, sinal_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] base;
  logic          last;
  logic          push;
  logic          pop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = 1'b0;
    // clear flushes first so a same-cycle pulso is judged against an empty queue
    base       = clear ? '0 : pending_q;
    last       = (cnt_q == '0);
    pending_d  = base;
    overflow_d = clear ? 1'b0 : overflow_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pulso) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (pulso) begin
          cnt_d = HIGH_LOAD;
        end else if (last) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        push = pulso;
        if (last) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (last) begin
          if (base != '0) begin
            // queued event wins; a simultaneous pulso takes its place in the queue
            pop     = 1'b1;
            push    = pulso;
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else if (pulso) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          push  = pulso;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (push && !pop) begin
      if (base == DEPTH) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = base + PW'(1);
      end
    end else if (pop && !push) begin
      pending_d = base - PW'(1);
    end

    sinal_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      sinal_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      sinal_q    <= sinal_d;
      busy_q     <= busy_d;
    end
  end

  assign sinal    = sinal_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
